// File: rtl/mux_sel_arb.sv
// mux_sel_arb: registered N-channel selector, addressed or round-robin grant, valid/ready on both sides
// Ports: clk, reset_n (async, active-low); mode/addr pick the grant source;
//   in_data/in_valid/in_ready per channel; out_data/out_src/out_valid/out_ready output register;
//   xfer_count counts completed output handshakes (wrapping).
// Define MUX_SEL_ARB_RR_EN to build the round-robin arbiter; otherwise mode is ignored.
module mux_sel_arb #(
   parameter int WIDTH = 32,
   parameter int NUM_IN = 4,
   localparam int SEL_W = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        addr,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_src,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [15:0]             xfer_count
);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t state, state_nx;
   logic [SEL_W-1:0] grant;
   logic grant_found, load_en;
   logic [WIDTH-1:0] sel_data;
   assign out_valid = state == FULL;
   // reset_n gating keeps in_ready low while the block is held in reset
   assign load_en = reset_n && (!out_valid || out_ready) && grant_found;
`ifdef MUX_SEL_ARB_RR_EN
   logic [SEL_W-1:0] ptr;
   always_comb begin
      grant = addr;
      grant_found = int'(addr) < NUM_IN && in_valid[addr];
      if (mode) begin
         grant = '0;
         grant_found = 1'b0;
         // descending scan: the channel nearest ptr is written last and wins
         for (int i = NUM_IN - 1; i >= 0; i--)
            if (in_valid[SEL_W'((int'(ptr) + i) % NUM_IN)]) begin
               grant = SEL_W'((int'(ptr) + i) % NUM_IN);
               grant_found = 1'b1;
            end
      end
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) ptr <= '0;
      else if (load_en && mode) ptr <= grant == SEL_W'(NUM_IN - 1) ? '0 : grant + 1'b1;
`else
   logic unused_mode;
   assign unused_mode = mode;
   always_comb begin
      grant = addr;
      grant_found = int'(addr) < NUM_IN && in_valid[addr];
   end
`endif
   always_comb begin
      sel_data = '0;
      in_ready = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant == SEL_W'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
         in_ready[i] = load_en && grant == SEL_W'(i);
      end
      state_nx = load_en ? FULL : (out_ready ? EMPTY : state);
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= EMPTY;
         out_data <= '0;
         out_src <= '0;
         xfer_count <= '0;
      end else begin
         state <= state_nx;
         if (load_en) begin
            out_data <= sel_data;
            out_src <= grant;
         end
         if (out_valid && out_ready) xfer_count <= xfer_count + 16'd1;
      end
endmodule

// File: doc/mux_sel_arb.md
# mux_sel_arb

Parametrised registered N-channel, W-bit selector with valid/ready handshaking; successor to the fixed 32-bit two-input word selector. Chooses one of `NUM_IN` source channels per cycle, either by explicit address or by round-robin arbitration. Captures the chosen word in an output register with source tag and transfer counter. Sits between multiple producers (register-file ports, ALU results, memory read data) and a single consumer stage of the datapath.

## Interface
- `WIDTH`, 32, data width per channel (≥1)
- `NUM_IN`, 4, number of source channels (≥2; need not be a power of two)
- `SEL_W`, localparam = clog2(`NUM_IN`), width of address/source fields
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `mode`  in  1  0 = addressed select, 1 = round-robin
- `addr`  in  `SEL_W`  channel index used in addressed mode
- `in_data`  in  `NUM_IN*WIDTH`  packed channel data; channel k at [k*WIDTH +: WIDTH]
- `in_valid`  in  `NUM_IN`  per-channel valid
- `in_ready`  out  `NUM_IN`  per-channel ready; one-hot or zero
- `out_data`  out  `WIDTH`  registered selected word
- `out_src`  out  `SEL_W`  index of channel that supplied `out_data`
- `out_valid`  out  1  output register holds a word
- `out_ready`  in  1  consumer accepts
- `xfer_count`  out  16  completed output handshakes, wrapping

## Operation
- Output register has two states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- `load_en` = (!`out_valid` | `out_ready`) & grant_found.
- The register loads on `load_en`, sets `out_valid`, and captures the granted channel's data and index.
- FULL→EMPTY when `out_ready` & !`load_en`.
- FULL stays FULL on a simultaneous drain and load, giving back-to-back throughput.
- Addressed mode: grant_found = `addr` < `NUM_IN` & `in_valid[addr]`; grant = `addr`.
  - Out-of-range `addr` grants nothing. Valid on other channels is ignored.
- Round-robin mode: internal pointer `ptr` (`SEL_W` bits).
  - Grant goes to the first channel with valid set, searching `ptr`, `ptr`+1, … with wrap at `NUM_IN`-1→0.
  - On `load_en`, `ptr` ← grant+1, wrapping `NUM_IN`-1→0.
  - No valid or no load: `ptr` holds.
- `in_ready[k]` = `load_en` & (grant==k); all zero otherwise.
  - An input transfer occurs iff `in_valid[k]` & `in_ready[k]`.
  - Producers must hold data and valid until accepted.
- `xfer_count` += 1 on `out_valid` & `out_ready`; wraps 0xFFFF→0.
- `mode` and `addr` are sampled combinationally each cycle. A change never disturbs a FULL register. `ptr` is preserved across mode changes.
- Reset (asynchronous, any time, including mid-transfer):
  - `out_valid`=0, `out_data`=0, `out_src`=0, `ptr`=0, `xfer_count`=0.
  - `in_ready` is 0 while `reset_n` is low.

## Timing
- Latency: channel accepted at edge n → `out_valid`/`out_data` visible after edge n.
- Throughput: one word per cycle while `out_ready`=1 and a grant exists.
- Combinational paths: `in_valid`, `mode`, `addr`, `out_ready` → `in_ready`. No path from inputs to `out_*`.
- `xfer_count` updates on the edge that completes the output handshake.
- Reset deassertion: first load possible on the first rising edge after `reset_n` goes high.

## Configuration
- `MUX_SEL_ARB_RR_EN`
  - Defined: round-robin logic and `ptr` are compiled in; `mode` behaves as above.
  - Undefined: no `ptr`, no arbitration logic; `mode` is ignored and the block always operates in addressed mode.

## Test plan
- Reset mid-operation: FULL with `out_data`=0x12345678, `xfer_count`=3, pull `reset_n` low between edges → `out_valid`=0, `out_data`=0, `xfer_count`=0 immediately, `in_ready`=0.
- Addressed: `NUM_IN`=4, `mode`=0, `addr`=2, `in_valid`=4'b1111, ch2=0xDEADBEEF, `out_ready`=1 → `in_ready`=4'b0100; next cycle `out_data`=0xDEADBEEF, `out_src`=2.
- Backpressure: FULL, `out_ready`=0 for 5 cycles with all inputs valid → `in_ready`=0, `out_data`/`out_src` stable; raise `out_ready` → same cycle `in_ready` one-hot and new word loads on that edge; `xfer_count` +1.
- Round-robin fairness (macro defined): `mode`=1, `in_valid`=4'b1111, `out_ready`=1 for 5 cycles from reset → `out_src` sequence 0,1,2,3,0; `xfer_count`=4 after the fifth load (5 after one more drain).
- Round-robin skip/wrap: `ptr`=1, `in_valid`=4'b1001 → grants 3 then 0; `ptr` ends at 1.
- Macro undefined: `mode`=1, `addr`=1, `in_valid`=4'b1111 → only channel 1 granted every cycle; `out_src`=1 repeatedly.
